led_pwm: RTL
============

LED_PWM -- requirements
Module: led_pwm

Interface
REQ-001 SHALL have parameter PRESC_W, default 16, width of prescaler register and counter.
REQ-002 SHALL have parameter PRESC_RST, default 0, reset value of PRESC register.
REQ-003 SHALL have one clock and a synchronous, active-low reset; all state changes occur on rising clk only.
REQ-004 SHALL have ports (name, direction, width, meaning):
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- peri_req  in  1  bus request, already decoded to this block
- peri_addr  in  32  byte address; only [3:2] used
- peri_write  in  1  1 = write, 0 = read
- peri_be  in  4  byte enables for writes
- peri_wdata  in  32  write data
- peri_gnt  out  1  request accepted
- peri_rvalid  out  1  response valid
- peri_rdata  out  32  read data, valid with peri_rvalid
- led  out  4  PWM outputs, bit i = channel i

Function
REQ-005 SHALL drive peri_gnt combinationally equal to peri_req; every request is accepted in its cycle.
REQ-006 SHALL assert peri_rvalid for exactly one cycle, the cycle after each granted request, for both reads and writes.
REQ-007 SHALL return peri_rdata = 0 on write responses and whenever peri_rvalid = 0.
REQ-008 SHALL implement these registers, selected by peri_addr[3:2]:
- 0 CTRL: [3:0] channel enable, RW; other bits read 0
- 1 PRESC: [PRESC_W-1:0] divide value, RW
- 2 DUTY: byte i = shadow duty of channel i, RW
- 3 STATUS: [7:0] current PWM counter, RO; [8] WRAP sticky flag, write-1-to-clear
REQ-009 SHALL apply writes byte-wise per peri_be in the grant cycle; bytes with be = 0 stay unchanged.
REQ-010 SHALL return read data captured from register state in the grant cycle.
REQ-011 SHALL keep prescaler counter pc and 8-bit PWM counter cnt running only while CTRL[3:0] != 0.
REQ-012 While running, pc SHALL count 0..PRESC; tick = (pc == PRESC); on tick pc returns to 0 and cnt increments mod 256. PRESC = 0 SHALL give one tick per clock.
REQ-013 Any granted write to PRESC SHALL clear pc to 0 in the same edge; cnt is unaffected.
REQ-014 When CTRL[3:0] == 0, pc and cnt SHALL be held at 0 and active duty SHALL load from shadow DUTY every cycle.
REQ-015 On a tick where cnt == 255 (wrap to 0), active duty SHALL load all four shadow bytes and STATUS.WRAP SHALL set.
REQ-016 Active duty SHALL change only per REQ-014/REQ-015, so a DUTY write mid-period never alters the current period.
REQ-017 A simultaneous WRAP set and write-1-to-clear SHALL leave WRAP = 1.
REQ-018 led[i] SHALL be registered: next led[i] = CTRL[i] and (cnt < active_duty[i]), one cycle after cnt changes.
REQ-019 Duty 0 SHALL give constant 0; duty 255 SHALL give 255 high of 256 counter steps.
REQ-020 Clearing CTRL[i] SHALL force led[i] to 0 on the next cycle; other channels are unaffected.

Reset
REQ-021 With rst_n = 0 at a rising edge: CTRL, DUTY, active duty, pc, cnt, WRAP, led, peri_rvalid, peri_rdata SHALL become 0, and PRESC SHALL become PRESC_RST.
REQ-022 Reset SHALL override any request in the same cycle; no rvalid SHALL follow a request coincident with reset.
REQ-023 peri_gnt SHALL still follow peri_req during reset.

Verification
REQ-024 Register R/W: write 0xA5 to CTRL, then read CTRL -> rvalid one cycle after grant, rdata = 0x5. Write DUTY with be = 0b0010, wdata 0x0000_3300 -> readback 0x0000_3300 from reset.
REQ-025 PWM timing: PRESC = 0, DUTY = 0x00FF_8040, CTRL = 0xF -> per 256 cycles led[0] high 64, led[1] 128, led[2] 255, led[3] 0; WRAP sets every 256 cycles.
REQ-026 Prescaler: PRESC = 3, CTRL = 1 -> cnt increments every 4 clocks; a PRESC write mid-count restarts pc at 0.
REQ-027 Shadow duty: DUTY byte0 0x40 to 0xC0 written at cnt = 0x10 -> led[0] period unchanged until the next wrap, then high 192 steps.
REQ-028 WRAP race: write STATUS = 0x100 on the wrap tick edge -> WRAP reads 1; a write one cycle later -> WRAP reads 0.
REQ-029 Reset mid-operation: assert rst_n = 0 with led active and a read pending -> next cycle all outputs 0, PRESC = PRESC_RST, no rvalid.

Source files
------------

// File: rtl/led_pwm.sv
// Four-channel 8-bit LED PWM with a prescaled counter and a simple
// request/grant register bus (CTRL, PRESC, DUTY, STATUS).
module led_pwm #(
  parameter int                 PRESC_W   = 16,
  parameter logic [PRESC_W-1:0] PRESC_RST = '0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        peri_req,
  input  logic [31:0] peri_addr,
  input  logic        peri_write,
  input  logic [3:0]  peri_be,
  input  logic [31:0] peri_wdata,
  output logic        peri_gnt,
  output logic        peri_rvalid,
  output logic [31:0] peri_rdata,
  output logic [3:0]  led
);

  logic [3:0]         ctrl;
  logic [PRESC_W-1:0] presc;
  logic [PRESC_W-1:0] pc;
  logic [31:0]        duty;
  logic [31:0]        act;
  logic [7:0]         cnt;
  logic               wrap;

  logic [1:0]  sel;
  logic        wr;
  logic [31:0] wmask;
  logic        run;
  logic        tick;
  logic        wrap_set;
  logic        wrap_clr;
  logic        presc_wr;
  logic [31:0] rd_mux;
  logic [3:0]  led_nxt;

  logic unused_addr;
  assign unused_addr = ^{peri_addr[31:4], peri_addr[1:0]};

  assign peri_gnt = peri_req;

  always_comb begin
    sel      = peri_addr[3:2];
    wr       = peri_req & peri_write;
    wmask    = {{8{peri_be[3]}}, {8{peri_be[2]}},
                {8{peri_be[1]}}, {8{peri_be[0]}}};
    run      = |ctrl;
    tick     = run && (pc == presc);
    wrap_set = tick && (cnt == 8'hFF);
    presc_wr = wr && (sel == 2'd1);
    wrap_clr = wr && (sel == 2'd3) && peri_be[1] && peri_wdata[8];
    rd_mux   = '0;
    case (sel)
      2'd0:    rd_mux = {28'd0, ctrl};
      2'd1:    rd_mux = 32'(presc);
      2'd2:    rd_mux = duty;
      default: rd_mux = {23'd0, wrap, cnt};
    endcase
    for (int i = 0; i < 4; i++) begin
      led_nxt[i] = ctrl[i] && (cnt < act[8*i +: 8]);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ctrl        <= '0;
      presc       <= PRESC_RST;
      pc          <= '0;
      duty        <= '0;
      act         <= '0;
      cnt         <= '0;
      wrap        <= 1'b0;
      led         <= '0;
      peri_rvalid <= 1'b0;
      peri_rdata  <= '0;
    end else begin
      peri_rvalid <= peri_req;
      peri_rdata  <= (peri_req && !peri_write) ? rd_mux : '0;
      led         <= led_nxt;
      wrap        <= wrap_set | (wrap & ~wrap_clr);
      // Active duty only reloads while idle or at a period wrap
      if (!run) begin
        pc  <= '0;
        cnt <= '0;
        act <= duty;
      end else if (tick) begin
        pc  <= '0;
        cnt <= cnt + 8'd1;
        if (cnt == 8'hFF) act <= duty;
      end else begin
        pc <= pc + PRESC_W'(1);
      end
      if (presc_wr) begin
        pc    <= '0;
        presc <= (presc & ~wmask[PRESC_W-1:0]) |
                 (peri_wdata[PRESC_W-1:0] & wmask[PRESC_W-1:0]);
      end
      if (wr && (sel == 2'd0) && peri_be[0]) ctrl <= peri_wdata[3:0];
      if (wr && (sel == 2'd2)) duty <= (duty & ~wmask) | (peri_wdata & wmask);
    end
  end

endmodule
